// File: rtl/rv32i_wb_arbiter.sv
// rv32i_wb_arbiter: round-robin arbiter for the register file's single writeback port, with registered outputs.
// Also keeps a saturating count of contended cycles for perf debug.
module rv32i_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int CNT_W   = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*5-1:0]    req_reg,
   input  logic [NUM_REQ*32-1:0]   req_data,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic                    wb_hold,
   output logic                    wb_enable,
   output logic [4:0]              wb_reg,
   output logic [31:0]             wb_data,
   output logic [CNT_W-1:0]        contend_cnt
);
   localparam int PW = $clog2(NUM_REQ);
   logic [PW-1:0] rr_ptr, nxt_ptr;
   logic          xfer, contended;
   logic [4:0]    sel_reg;
   logic [31:0]   sel_data;
   int            best, gi, d;
   // The winner is the valid requester with the smallest circular distance from rr_ptr.
   always_comb begin
      best = NUM_REQ;
      gi = 0;
      d = 0;
      sel_reg = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         d = (i + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
         if (req_valid[i] && d < best) begin
            best = d;
            gi = i;
            sel_reg = req_reg[5*i +: 5];
            sel_data = req_data[32*i +: 32];
         end
      end
      xfer = best < NUM_REQ && !wb_hold && !reset;
      for (int i = 0; i < NUM_REQ; i++) req_ready[i] = xfer && gi == i;
      nxt_ptr = PW'((gi + 1) % NUM_REQ);
      contended = $countones(req_valid) > 1;
   end
   // x0 writes are consumed but never strobed, and leave the address/data registers alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_enable <= 1'b0;
         wb_reg <= '0;
         wb_data <= '0;
         rr_ptr <= '0;
         contend_cnt <= '0;
      end else begin
         wb_enable <= xfer && sel_reg != 5'd0;
         if (xfer && sel_reg != 5'd0) begin
            wb_reg <= sel_reg;
            wb_data <= sel_data;
         end
         if (xfer) rr_ptr <= nxt_ptr;
         if (contended && !(&contend_cnt)) contend_cnt <= contend_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// tb_rv32i_wb_arbiter: directed table plus random stimulus against a behavioural arbiter model.
// A second instance with a 4-bit counter exercises saturation.
module tb_rv32i_wb_arbiter;
   localparam int N = 3;
   logic          clk = 1'b0;
   logic          reset, wb_hold;
   logic [2:0]    req_valid, req_ready, req_ready4;
   logic [14:0]   req_reg;
   logic [95:0]   req_data;
   logic          wb_enable, wb_enable4;
   logic [4:0]    wb_reg, wb_reg4;
   logic [31:0]   wb_data, wb_data4;
   logic [15:0]   contend_cnt;
   logic [3:0]    contend_cnt4;
   logic [31:0]   rf [32];
   int            n_cmp = 0, n_bad = 0;
   int            m_ptr, m_cnt, m_cnt4;
   logic          m_en;
   logic [4:0]    m_reg;
   logic [31:0]   m_data;

   always #5 clk = ~clk;

   rv32i_wb_arbiter #(.NUM_REQ(N), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
      .req_ready(req_ready), .wb_hold(wb_hold), .wb_enable(wb_enable), .wb_reg(wb_reg),
      .wb_data(wb_data), .contend_cnt(contend_cnt));

   rv32i_wb_arbiter #(.NUM_REQ(N), .CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
      .req_ready(req_ready4), .wb_hold(wb_hold), .wb_enable(wb_enable4), .wb_reg(wb_reg4),
      .wb_data(wb_data4), .contend_cnt(contend_cnt4));

   // Register file stand-in: ignores writes while reset is asserted, x0 never written.
   always @(posedge clk)
      if (!reset && wb_enable && wb_reg != 5'd0) rf[wb_reg] <= wb_data;

   typedef struct {
      logic        rst;
      logic        hold;
      logic [2:0]  valid;
      logic [14:0] regs;
      logic [95:0] data;
      logic [2:0]  ready;
      logic        en;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic int model_grant();
      if (reset || wb_hold) return -1;
      for (int k = 0; k < N; k++)
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   task automatic run_cycle(input bit use_tbl, input logic [2:0] t_ready, input logic t_en);
      int g;
      logic [2:0] er;
      logic [4:0] r;
      @(negedge clk);
      g = model_grant();
      er = (g < 0) ? 3'b000 : 3'(1 << g);
      check("req_ready", 32'(req_ready), 32'(use_tbl ? t_ready : er));
      check("req_ready_sat", 32'(req_ready4), 32'(er));
      if (reset) begin
         m_en = 1'b0; m_reg = '0; m_data = '0; m_ptr = 0; m_cnt = 0; m_cnt4 = 0;
      end else begin
         if ($countones(req_valid) >= 2) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
         end
         m_en = 1'b0;
         if (g >= 0) begin
            m_ptr = (g + 1) % N;
            r = req_reg[5*g +: 5];
            if (r != 5'd0) begin
               m_en = 1'b1;
               m_reg = r;
               m_data = req_data[32*g +: 32];
            end
         end
      end
      @(posedge clk);
      #1;
      check("wb_enable", 32'(wb_enable), 32'(use_tbl ? t_en : m_en));
      check("wb_reg", 32'(wb_reg), 32'(m_reg));
      check("wb_data", wb_data, m_data);
      check("contend_cnt", 32'(contend_cnt), 32'(m_cnt));
      check("contend_cnt_sat", 32'(contend_cnt4), 32'(m_cnt4));
   endtask

   initial begin
      vec_t tbl [20];
      logic [14:0] rg, rg0;
      logic [95:0] dt, dt0, dt6;
      rg  = {5'd3, 5'd5, 5'd7};
      rg0 = {5'd0, 5'd5, 5'd7};
      dt  = {32'hC0C0_0002, 32'hDEAD_BEEF, 32'hA0A0_0000};
      dt0 = {32'h0000_1234, 32'hDEAD_BEEF, 32'hA0A0_0000};
      dt6 = {32'h6666_6666, 32'hDEAD_BEEF, 32'hA0A0_0000};
      tbl[0]  = '{1'b1, 1'b0, 3'b111, rg,  dt,  3'b000, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 3'b111, rg,  dt,  3'b000, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 3'b111, rg,  dt,  3'b001, 1'b1};
      tbl[3]  = '{1'b0, 1'b0, 3'b111, rg,  dt,  3'b010, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 3'b111, rg,  dt,  3'b100, 1'b1};
      tbl[5]  = '{1'b0, 1'b0, 3'b111, rg,  dt,  3'b001, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 3'b111, rg,  dt,  3'b010, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 3'b111, rg,  dt,  3'b100, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 3'b010, rg,  dt,  3'b010, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 3'b000, rg,  dt,  3'b000, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 3'b100, rg0, dt0, 3'b100, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 3'b000, rg,  dt,  3'b000, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 3'b001, rg,  dt,  3'b000, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 3'b001, rg,  dt,  3'b000, 1'b0};
      tbl[14] = '{1'b0, 1'b1, 3'b001, rg,  dt,  3'b000, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 3'b001, rg,  dt,  3'b001, 1'b1};
      tbl[16] = '{1'b0, 1'b0, 3'b011, rg,  dt,  3'b010, 1'b1};
      tbl[17] = '{1'b0, 1'b0, 3'b100, rg,  dt6, 3'b100, 1'b1};
      tbl[18] = '{1'b1, 1'b0, 3'b111, rg,  dt,  3'b000, 1'b0};
      tbl[19] = '{1'b0, 1'b0, 3'b111, rg,  dt,  3'b001, 1'b1};
      m_ptr = 0; m_cnt = 0; m_cnt4 = 0; m_en = 1'b0; m_reg = '0; m_data = '0;
      for (int i = 0; i < 20; i++) begin
         reset = tbl[i].rst;
         wb_hold = tbl[i].hold;
         req_valid = tbl[i].valid;
         req_reg = tbl[i].regs;
         req_data = tbl[i].data;
         run_cycle(1'b1, tbl[i].ready, tbl[i].en);
      end
      check("rf_x5", rf[5], 32'hDEAD_BEEF);
      check("rf_x3_no_write_in_reset", rf[3], 32'hC0C0_0002);
      // Saturation: 20 contended cycles under hold.
      reset = 1'b1; wb_hold = 1'b0; req_valid = 3'b111;
      run_cycle(1'b0, 3'b000, 1'b0);
      reset = 1'b0; wb_hold = 1'b1;
      for (int i = 0; i < 20; i++) run_cycle(1'b0, 3'b000, 1'b0);
      check("sat_cnt4", 32'(contend_cnt4), 32'hF);
      check("sat_cnt16", 32'(contend_cnt), 32'd20);
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom % 32) == 0;
         wb_hold = ($urandom % 4) == 0;
         req_valid = 3'($urandom);
         req_reg = 15'($urandom);
         req_data = {$urandom, $urandom, $urandom};
         run_cycle(1'b0, 3'b000, 1'b0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
